segasys1_hvgen: RTL
===================

SEGASYS1_HVGEN -- requirements
Module: segasys1_hvgen

Interface
REQ-001 SHALL have parameter HTOTAL, default 320: pixels per line; PH counts 0..HTOTAL-1.
REQ-002 SHALL have parameter VTOTAL, default 262: lines per frame; PV counts 0..VTOTAL-1.
REQ-003 SHALL have parameters HS_START, default 280, and HS_END, default 311: inclusive HSYNC pixel window before offset is applied.
REQ-004 SHALL have parameters VS_START, default 234, and VS_END, default 236: inclusive VSYNC line window before offset is applied.
REQ-005 SHALL have port VCLKx8, input, 1 bit: the single clock of the block (8x pixel rate); all logic is clocked on its rising edge.
REQ-006 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port HOFS, input, 4 bits: signed HSYNC shift in pixels, range -8..+7.
REQ-008 SHALL have port VOFS, input, 3 bits: signed VSYNC shift in lines, range -4..+3.
REQ-009 SHALL have port IRQ_ACK, input, 1 bit: CPU interrupt acknowledge, level-sampled.
REQ-010 SHALL have port PCLK_EN, output, 1 bit: pixel-clock enable, high one cycle in every eight.
REQ-011 SHALL have port PH, output, 9 bits: horizontal pixel counter, consumed by the video block.
REQ-012 SHALL have port PV, output, 9 bits: vertical line counter, consumed by the video block.
REQ-013 SHALL have ports HBLK and VBLK, output, 1 bit each: blanking flags.
REQ-014 SHALL have ports HSYNC and VSYNC, output, 1 bit each: sync signals, active-high.
REQ-015 SHALL have port IRQ_N, output, 1 bit: vertical-blank interrupt request to the CPU, active-low.
REQ-016 SHALL have port IRQ_OVR, output, 1 bit: sticky flag set when a new frame interrupt is requested while the previous one is still pending.

Function
REQ-017 SHALL count VCLKx8 cycles in a 3-bit divider (0..7, wrapping), and SHALL drive PCLK_EN as a registered output that is high exactly in the cycle following the cycle in which the divider equals 7.
REQ-018 SHALL update PH, PV, HBLK, VBLK, HSYNC and VSYNC only on rising edges of VCLKx8 at which PCLK_EN is 1; at all other edges these outputs SHALL hold.
REQ-019 SHALL increment PH by 1 on each update, and SHALL wrap PH from HTOTAL-1 to 0.
REQ-020 SHALL increment PV by 1 on the same update in which PH wraps, and SHALL wrap PV from VTOTAL-1 to 0.
REQ-021 SHALL decode every flag from the next-state counter values, so that each flag is registered together with, and aligned to, the PH/PV value it describes.
REQ-022 SHALL drive HBLK = 1 exactly when PH >= 256.
REQ-023 SHALL drive VBLK = 1 exactly when PV >= 224.
REQ-024 SHALL drive HSYNC = 1 exactly when PH is in the range [HS_START+HOFS, HS_END+HOFS], using 10-bit signed arithmetic with no wrap.
REQ-025 SHALL drive VSYNC = 1 exactly when PV is in the range [VS_START+VOFS, VS_END+VOFS], using 10-bit signed arithmetic with no wrap.
REQ-026 SHALL sample HOFS and VOFS into shadow registers only on the update where both PH and PV wrap to 0 (frame start); a change in HOFS or VOFS mid-frame SHALL NOT affect the current frame.
REQ-027 SHALL run an interrupt FSM with states IDLE and PEND.
REQ-028 SHALL, in state IDLE, move to PEND on the update at which PV becomes 224 while PH becomes 0.
REQ-029 SHALL, in state PEND, return to IDLE on any VCLKx8 edge at which IRQ_ACK = 1.
REQ-030 SHALL drive IRQ_N = 0 exactly while the FSM is in PEND; IRQ_N SHALL be registered.
REQ-031 SHALL give priority to the new request when the frame-start trigger and IRQ_ACK coincide: the FSM SHALL stay in, or enter, PEND.
REQ-032 SHALL set IRQ_OVR when the trigger occurs while the FSM is already in PEND; IRQ_OVR SHALL be cleared only by reset.

Reset
REQ-033 SHALL, while RESET_N = 0, asynchronously force: divider = 0, PCLK_EN = 0, PH = 0, PV = 0, HBLK = 0, VBLK = 0, HSYNC = 0, VSYNC = 0, IRQ_N = 1, IRQ_OVR = 0, FSM = IDLE, shadow offsets = 0.
REQ-034 SHALL, after reset is released, assert the first PCLK_EN on the 8th rising edge, and SHALL first change PH (0->1) on the 9th rising edge.
REQ-035 SHALL, when reset is asserted mid-frame, return all outputs to their reset values immediately, without waiting for a clock edge.

Verification
REQ-036 Release reset, then run 8*320*262 cycles -> PCLK_EN high every 8th cycle; PH wraps 319->0; PV wraps 261->0; exactly one frame elapsed.
REQ-037 HOFS = 0, VOFS = 0 -> HSYNC high for PH 280..311 (32 pixels); VSYNC high for PV 234..236; HBLK first rises at PH = 256; VBLK first rises at PV = 224.
REQ-038 Set HOFS = -8 mid-frame -> current frame keeps HSYNC at 280..311; next frame has HSYNC at 272..303.
REQ-039 Reach PV = 224, PH = 0 -> IRQ_N falls; IRQ_ACK pulsed 10 cycles later -> IRQ_N rises on that edge.
REQ-040 Never acknowledge for two frames -> IRQ_OVR = 1 at the second trigger; IRQ_ACK asserted coincident with a trigger -> IRQ_N stays 0.
REQ-041 Assert RESET_N = 0 at PH = 100, PV = 230 -> PH = 0, PV = 0, VBLK = 0, IRQ_N = 1 with no clock edge required.

Source files
------------

// File: rtl/segasys1_hvgen.sv
// Video timing generator: 8x pixel-clock divider, PH/PV raster counters,
// blanking/sync decode with frame-latched sync offsets, and the
// vertical-blank interrupt request with overrun flag.
//
// IRQ FSM states
//   state  | meaning
//   S_IDLE | no interrupt outstanding, IRQ_N high
//   S_PEND | frame interrupt requested, waiting for IRQ_ACK, IRQ_N low
module segasys1_hvgen #(
  parameter int HTOTAL   = 320,
  parameter int VTOTAL   = 262,
  parameter int HS_START = 280,
  parameter int HS_END   = 311,
  parameter int VS_START = 234,
  parameter int VS_END   = 236
) (
  input  logic       VCLKx8,
  input  logic       RESET_N,
  input  logic [3:0] HOFS,
  input  logic [2:0] VOFS,
  input  logic       IRQ_ACK,
  output logic       PCLK_EN,
  output logic [8:0] PH,
  output logic [8:0] PV,
  output logic       HBLK,
  output logic       VBLK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       IRQ_N,
  output logic       IRQ_OVR
);

  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} irq_state_t;

  logic [2:0] r_div;
  logic       r_pclk_en;
  logic [8:0] r_ph;
  logic [8:0] r_pv;
  logic       r_hblk;
  logic       r_vblk;
  logic       r_hsync;
  logic       r_vsync;
  logic [3:0] r_hofs;
  logic [2:0] r_vofs;
  logic       r_irq_n;
  logic       r_irq_ovr;
  irq_state_t r_state;
  irq_state_t w_state_nxt;
  logic       w_ovr_set;

  logic        w_ph_wrap;
  logic        w_pv_wrap;
  logic [8:0]  w_ph_nxt;
  logic [8:0]  w_pv_nxt;
  logic        w_frame_start;
  logic        w_trig;
  logic [3:0]  w_hofs_eff;
  logic [2:0]  w_vofs_eff;
  logic signed [9:0] w_hofs_ext;
  logic signed [9:0] w_vofs_ext;
  logic signed [9:0] w_hs_lo;
  logic signed [9:0] w_hs_hi;
  logic signed [9:0] w_vs_lo;
  logic signed [9:0] w_vs_hi;
  logic signed [9:0] w_ph_s;
  logic signed [9:0] w_pv_s;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;

  assign w_ph_wrap     = (r_ph == 9'(HTOTAL - 1));
  assign w_pv_wrap     = (r_pv == 9'(VTOTAL - 1));
  assign w_ph_nxt      = w_ph_wrap ? 9'd0 : r_ph + 9'd1;
  assign w_pv_nxt      = w_ph_wrap ? (w_pv_wrap ? 9'd0 : r_pv + 9'd1) : r_pv;
  assign w_frame_start = r_pclk_en && w_ph_wrap && w_pv_wrap;
  assign w_trig        = r_pclk_en && w_ph_wrap && (w_pv_nxt == 9'd224);

  // The first pixel of a new frame is decoded with the offsets it latches,
  // so a whole frame always uses one consistent pair of offsets.
  assign w_hofs_eff = w_frame_start ? HOFS : r_hofs;
  assign w_vofs_eff = w_frame_start ? VOFS : r_vofs;
  assign w_hofs_ext = {{6{w_hofs_eff[3]}}, w_hofs_eff};
  assign w_vofs_ext = {{7{w_vofs_eff[2]}}, w_vofs_eff};

  assign w_hs_lo = 10'(HS_START) + w_hofs_ext;
  assign w_hs_hi = 10'(HS_END)   + w_hofs_ext;
  assign w_vs_lo = 10'(VS_START) + w_vofs_ext;
  assign w_vs_hi = 10'(VS_END)   + w_vofs_ext;
  assign w_ph_s  = {1'b0, w_ph_nxt};
  assign w_pv_s  = {1'b0, w_pv_nxt};

  assign w_hsync_nxt = (w_ph_s >= w_hs_lo) && (w_ph_s <= w_hs_hi);
  assign w_vsync_nxt = (w_pv_s >= w_vs_lo) && (w_pv_s <= w_vs_hi);

  // Free-running divide-by-8 producing the registered pixel enable.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_div     <= 3'd0;
      r_pclk_en <= 1'b0;
    end else begin
      r_div     <= r_div + 3'd1;
      r_pclk_en <= (r_div == 3'd7);
    end
  end

  // Raster counters, flags and frame-latched offsets, advanced once per pixel.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ph    <= 9'd0;
      r_pv    <= 9'd0;
      r_hblk  <= 1'b0;
      r_vblk  <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_hofs  <= 4'd0;
      r_vofs  <= 3'd0;
    end else if (r_pclk_en) begin
      r_ph    <= w_ph_nxt;
      r_pv    <= w_pv_nxt;
      r_hblk  <= (w_ph_nxt >= 9'd256);
      r_vblk  <= (w_pv_nxt >= 9'd224);
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
      if (w_frame_start) begin
        r_hofs <= HOFS;
        r_vofs <= VOFS;
      end
    end
  end

  // IRQ next state: a new request outranks a simultaneous acknowledge.
  always_comb begin
    w_state_nxt = r_state;
    w_ovr_set   = 1'b0;
    if (w_trig) begin
      w_state_nxt = S_PEND;
      w_ovr_set   = (r_state == S_PEND);
    end else if ((r_state == S_PEND) && IRQ_ACK) begin
      w_state_nxt = S_IDLE;
    end
  end

  // IRQ state register with registered request and sticky overrun.
  always_ff @(posedge VCLKx8 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_irq_n   <= 1'b1;
      r_irq_ovr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_n   <= (w_state_nxt != S_PEND);
      r_irq_ovr <= r_irq_ovr | w_ovr_set;
    end
  end

  assign PCLK_EN = r_pclk_en;
  assign PH      = r_ph;
  assign PV      = r_pv;
  assign HBLK    = r_hblk;
  assign VBLK    = r_vblk;
  assign HSYNC   = r_hsync;
  assign VSYNC   = r_vsync;
  assign IRQ_N   = r_irq_n;
  assign IRQ_OVR = r_irq_ovr;

endmodule
